// File: rtl/defines.sv
// Shared datapath constants and the ID/EX pipeline register layout.
package defines;
    localparam int N                 = 32;
    localparam int REG_FILE_ADDR_LEN = 5;
    localparam int REG_FILE_SIZE     = 1 << REG_FILE_ADDR_LEN;
    localparam int OP_W              = 4;

    typedef logic [OP_W-1:0] op_t;

    typedef struct packed {
        logic [N-1:0]                 a;
        logic [N-1:0]                 b;
        logic [N-1:0]                 imm;
        op_t                          op;
        logic [REG_FILE_ADDR_LEN-1:0] dest;
        logic                         wr_en;
        logic                         is_load;
    } id_ex_t;
endpackage

// File: rtl/hazard_detect.sv
// Load-use compare between the held ID/EX instruction and the incoming sources.
module hazard_detect #(
    parameter int AW = defines::REG_FILE_ADDR_LEN
) (
    input  logic          in_valid,
    input  logic          held_valid,
    input  logic          held_is_load,
    input  logic          held_wr_en,
    input  logic [AW-1:0] held_dest,
    input  logic [AW-1:0] src1,
    input  logic [AW-1:0] src2,
    output logic          hazard
);
    // r0 is hardwired to zero, so a load into it can never create a dependency.
    assign hazard = in_valid && held_valid && held_is_load && held_wr_en
                 && (held_dest != '0)
                 && ((held_dest == src1) || (held_dest == src2));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: operand fetch with writeback bypass, handshake register, load-use stall.
module id_ex_stage
    import defines::*;
#(
    parameter int N     = defines::N,
    parameter int AW    = defines::REG_FILE_ADDR_LEN,
    parameter int OP_W  = defines::OP_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_src1,
    input  logic [AW-1:0]    in_src2,
    input  logic [AW-1:0]    in_dest,
    input  logic [N-1:0]     in_imm,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_wr_en,
    input  logic             in_is_load,
    output logic [AW-1:0]    rf_src1,
    output logic [AW-1:0]    rf_src2,
    input  logic [N-1:0]     rf_reg1,
    input  logic [N-1:0]     rf_reg2,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_dest,
    input  logic [N-1:0]     wb_val,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_a,
    output logic [N-1:0]     out_b,
    output logic [N-1:0]     out_imm,
    output logic [OP_W-1:0]  out_op,
    output logic [AW-1:0]    out_dest,
    output logic             out_wr_en,
    output logic             out_is_load,
    output logic [CNT_W-1:0] stall_cnt
);
    logic [N-1:0] a, b;
    logic         hazard, accept;
    id_ex_t       q, d;

    assign rf_src1 = in_src1;
    assign rf_src2 = in_src2;

    // Write-through bypass: the register file has not yet absorbed this cycle's writeback.
    always_comb begin
        a = rf_reg1;
        b = rf_reg2;
        if (in_src1 == '0)                     a = '0;
        else if (wb_en && wb_dest == in_src1)  a = wb_val;
        if (in_src2 == '0)                     b = '0;
        else if (wb_en && wb_dest == in_src2)  b = wb_val;
    end

    hazard_detect #(.AW(AW)) u_hazard (
        .in_valid     (in_valid),
        .held_valid   (out_valid),
        .held_is_load (q.is_load),
        .held_wr_en   (q.wr_en),
        .held_dest    (q.dest),
        .src1         (in_src1),
        .src2         (in_src2),
        .hazard       (hazard)
    );

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        d         = '0;
        d.a       = a;
        d.b       = b;
        d.imm     = in_imm;
        d.op      = in_op;
        d.dest    = in_dest;
        d.wr_en   = in_wr_en;
        d.is_load = in_is_load;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            q         <= d;
        end else if (out_valid && out_ready) begin
            // Bubble: dropping the load flags releases the hazard next cycle.
            out_valid <= 1'b0;
            q.wr_en   <= 1'b0;
            q.is_load <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cnt <= '0;
        else if (in_valid && hazard && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign out_a       = q.a;
    assign out_b       = q.b;
    assign out_imm     = q.imm;
    assign out_op      = q.op;
    assign out_dest    = q.dest;
    assign out_wr_en   = q.wr_en;
    assign out_is_load = q.is_load;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, bypass, load-use bubble, backpressure, flush, saturation.
module tb_id_ex_stage;
    localparam int N = 32, AW = 5, OP_W = 4, CNT_W = 16;

    logic             clk, rstn;
    logic             in_valid, in_ready;
    logic [AW-1:0]    in_src1, in_src2, in_dest;
    logic [N-1:0]     in_imm;
    logic [OP_W-1:0]  in_op;
    logic             in_wr_en, in_is_load;
    logic [AW-1:0]    rf_src1, rf_src2;
    logic [N-1:0]     rf_reg1, rf_reg2;
    logic             wb_en;
    logic [AW-1:0]    wb_dest;
    logic [N-1:0]     wb_val;
    logic             flush, out_valid, out_ready;
    logic [N-1:0]     out_a, out_b, out_imm;
    logic [OP_W-1:0]  out_op;
    logic [AW-1:0]    out_dest;
    logic             out_wr_en, out_is_load;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.N(N), .AW(AW), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest), .in_imm(in_imm),
        .in_op(in_op), .in_wr_en(in_wr_en), .in_is_load(in_is_load),
        .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_reg1(rf_reg1), .rf_reg2(rf_reg2),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_imm(out_imm), .out_op(out_op), .out_dest(out_dest), .out_wr_en(out_wr_en),
        .out_is_load(out_is_load), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                             input logic [AW-1:0] dst, input logic [N-1:0] imm,
                             input logic ld, input logic [N-1:0] r1, input logic [N-1:0] r2);
        in_valid = 1'b1; in_src1 = s1; in_src2 = s2; in_dest = dst; in_imm = imm;
        in_op = 4'h3; in_wr_en = 1'b1; in_is_load = ld; rf_reg1 = r1; rf_reg2 = r2;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; wb_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b1; in_valid = 1'b0; in_src1 = '0; in_src2 = '0; in_dest = '0;
        in_imm = '0; in_op = '0; in_wr_en = 1'b0; in_is_load = 1'b0;
        rf_reg1 = '0; rf_reg2 = '0; wb_en = 1'b0; wb_dest = '0; wb_val = '0;
        flush = 1'b0; out_ready = 1'b1;
        #2 rstn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_a !== '0) begin errors++; $display("FAIL reset_a got %h exp 0", out_a); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall got %h exp 0", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_accept();
        set_instr(5'd3, 5'd5, 5'd9, 32'd7, 1'b0, 32'h11, 32'h22);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_ready got %b exp 1", in_ready); end
        checks++; if (rf_src1 !== 5'd3 || rf_src2 !== 5'd5) begin errors++; $display("FAIL rf_addr got %0d/%0d exp 3/5", rf_src1, rf_src2); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL accept_valid got %b exp 1", out_valid); end
        checks++; if (out_a !== 32'h11 || out_b !== 32'h22) begin errors++; $display("FAIL accept_ab got %h/%h exp 11/22", out_a, out_b); end
        checks++; if (out_imm !== 32'd7 || out_op !== 4'h3 || out_dest !== 5'd9) begin errors++; $display("FAIL accept_payload got %h/%h/%0d exp 7/3/9", out_imm, out_op, out_dest); end
        drain();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_bypass();
        set_instr(5'd4, 5'd5, 5'd9, 32'd0, 1'b0, 32'h01, 32'h22);
        wb_en = 1'b1; wb_dest = 5'd4; wb_val = 32'hAA;
        tick();
        checks++; if (out_a !== 32'hAA || out_b !== 32'h22) begin errors++; $display("FAIL bypass_a got %h/%h exp aa/22", out_a, out_b); end
        set_instr(5'd0, 5'd5, 5'd9, 32'd0, 1'b0, 32'h55, 32'h22);
        wb_dest = 5'd0;
        tick();
        checks++; if (out_a !== '0 || out_b !== 32'h22) begin errors++; $display("FAIL bypass_r0 got %h/%h exp 0/22", out_a, out_b); end
        set_instr(5'd1, 5'd7, 5'd9, 32'd0, 1'b0, 32'h01, 32'h02);
        wb_dest = 5'd7; wb_val = 32'hBB;
        tick();
        checks++; if (out_a !== 32'h01 || out_b !== 32'hBB) begin errors++; $display("FAIL bypass_b got %h/%h exp 1/bb", out_a, out_b); end
        drain();
    endtask

    task automatic test_load_use();
        set_instr(5'd1, 5'd2, 5'd6, 32'h10, 1'b1, 32'h1, 32'h2);
        tick();
        checks++; if (out_valid !== 1'b1 || out_is_load !== 1'b1) begin errors++; $display("FAIL lu_load got %b/%b exp 1/1", out_valid, out_is_load); end
        set_instr(5'd1, 5'd6, 5'd8, 32'h21, 1'b0, 32'h1, 32'h2);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_ready got %b exp 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_is_load !== 1'b0 || out_wr_en !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b/%b/%b exp 0/0/0", out_valid, out_is_load, out_wr_en); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_dest !== 5'd8 || out_imm !== 32'h21) begin errors++; $display("FAIL lu_accept got %b/%0d/%h exp 1/8/21", out_valid, out_dest, out_imm); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_hold got %0d exp 1", stall_cnt); end
    endtask

    task automatic test_backpressure();
        set_instr(5'd10, 5'd11, 5'd12, 32'h33, 1'b0, 32'h44, 32'h55);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_imm !== 32'h21 || out_dest !== 5'd8) begin errors++; $display("FAIL bp_hold[%0d] got %b/%h/%0d exp 1/21/8", i, out_valid, out_imm, out_dest); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'h33 || out_a !== 32'h44 || out_dest !== 5'd12) begin errors++; $display("FAIL bp_swap got %b/%h/%h/%0d exp 1/33/44/12", out_valid, out_imm, out_a, out_dest); end
        drain();
    endtask

    task automatic test_flush();
        set_instr(5'd1, 5'd2, 5'd6, 32'h0, 1'b1, 32'h77, 32'h2);
        tick();
        set_instr(5'd6, 5'd2, 5'd3, 32'h0, 1'b0, 32'h1, 32'h2);
        flush = 1'b1; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_hz_ready got %b exp 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_hz_valid got %b exp 0", out_valid); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL flush_hz_cnt got %0d exp 2", stall_cnt); end
        flush = 1'b0; out_ready = 1'b1;
        set_instr(5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h1, 32'h2);
        tick();
        set_instr(5'd2, 5'd1, 5'd4, 32'h0, 1'b0, 32'h1, 32'h2);
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd2) begin errors++; $display("FAIL flush_valid got %b/%0d exp 0/2", out_valid, stall_cnt); end
        drain();
    endtask

    task automatic test_saturate_and_async_reset();
        set_instr(5'd1, 5'd2, 5'd6, 32'h0, 1'b1, 32'h77, 32'h2);
        tick();
        set_instr(5'd6, 5'd0, 5'd3, 32'h0, 1'b0, 32'h1, 32'h2);
        out_ready = 1'b0;
        repeat (65540) tick();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %h exp ffff", stall_cnt); end
        tick();
        checks++; if (stall_cnt !== 16'hFFFF || out_valid !== 1'b1 || out_a !== 32'h77) begin errors++; $display("FAIL sat_hold got %h/%b/%h exp ffff/1/77", stall_cnt, out_valid, out_a); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_a !== '0 || out_is_load !== 1'b0) begin errors++; $display("FAIL areset_state got %b/%h/%b exp 0/0/0", out_valid, out_a, out_is_load); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL areset_cnt got %h exp 0", stall_cnt); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_accept();
        test_bypass();
        test_load_use();
        test_backpressure();
        test_flush();
        test_saturate_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
